// File: rtl/ble_uart_pkg.sv
// Purpose: shared UART types and constants for the BLE link (rx and tx sides).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ble_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/ble_uart_sync.sv
// Purpose: N-flop synchronizer for a single asynchronous input.
// Latency: N clk_in cycles from async_in to sync_out.
// Backpressure: none; free-running.
// Ports:
//   clk_in   - system clock
//   rst_in   - synchronous, active-high reset; every flop loads RESET_VAL
//   async_in - asynchronous input
//   sync_out - synchronized copy of async_in
module ble_uart_sync #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= {N{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[N-2:0], async_in};
    end
  end

  assign sync_out = sync_q[N-1];

endmodule

// File: rtl/ble_uart_rx.sv
// Purpose: oversampling 8N1 UART receiver, LSB first, framing-error detection.
// Latency: valid_out/framing_err_out pulse one clk_in cycle after the mid-stop-bit sample tick.
// Backpressure: none; each good byte overwrites data_out whether or not it was consumed.
// Ports:
//   clk_in          - system clock
//   rst_in          - synchronous, active-high reset
//   tick_in         - oversample strobe, SAMPLE_RATE per bit period
//   rx_in           - asynchronous serial line, idles high
//   data_out        - last good byte, held until the next good byte
//   valid_out       - one-cycle pulse: data_out was just updated
//   framing_err_out - one-cycle pulse: stop bit read low, byte discarded
//   busy_out        - high while a frame is being received
// Build option: define UART_RX_MAJORITY_EN to take every sample as a 3-tick majority vote.
module ble_uart_rx
  import ble_uart_pkg::*;
#(
  parameter int SAMPLE_RATE = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tick_in,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       framing_err_out,
  output logic       busy_out
);

  localparam int CW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] MID  = CW'(SAMPLE_RATE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  logic rx_s;
  logic sample_bit;

  uart_rx_state state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;

  ble_uart_sync #(
    .N        (2),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .async_in(rx_in),
    .sync_out(rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Together with the current rx_s, the two previous ticked values form the
  // 3-sample vote window, so a lone glitch tick at the sample point loses.
  logic [1:0] hist_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hist_q <= 2'b11;
    end else if (tick_in) begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample_bit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (tick_in) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == MID) begin
            if (!sample_bit) begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              // Start bit did not hold to mid-bit: treat as noise.
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shift_d = {sample_bit, shift_q[UART_DATA_BITS-1:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            if (sample_bit) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            // Leaving at mid-stop leaves half a bit to catch the next start edge.
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out        = data_q;
  assign valid_out       = valid_q;
  assign framing_err_out = ferr_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_ble_uart_rx.sv
// Purpose: directed self-checking bench for ble_uart_rx with a serial frame driver.
// Latency: n/a.
// Backpressure: n/a.
module tb_ble_uart_rx;

  logic       clk_in;
  logic       rst_in;
  logic       tick_in;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       framing_err_out;
  logic       busy_out;

  int total = 0;
  int bad   = 0;

  int vcnt = 0;
  int fcnt = 0;
  int both = 0;
  int exp_v = 0;
  logic [7:0] got_q[$];

  ble_uart_rx #(.SAMPLE_RATE(16)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tick_in        (tick_in),
    .rx_in          (rx_in),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .framing_err_out(framing_err_out),
    .busy_out       (busy_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // One tick every 4 clocks, so the FSM must ignore non-tick cycles.
  initial begin
    tick_in = 1'b0;
    forever begin
      repeat (3) @(negedge clk_in);
      tick_in = 1'b1;
      @(negedge clk_in);
      tick_in = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out) begin
        vcnt++;
        got_q.push_back(data_out);
      end
      if (framing_err_out) fcnt++;
      if (valid_out && framing_err_out) both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk_in);
      while (tick_in !== 1'b1) @(posedge clk_in);
    end
  endtask

  // Each bit begins just after a tick edge and lasts 16 ticks; the receiver
  // samples on the 9th tick, where an optional one-tick low glitch is placed.
  task automatic drive_bit(input logic v, input bit glitch);
    @(negedge clk_in) rx_in = v;
    if (glitch) begin
      wait_ticks(8);
      @(negedge clk_in) rx_in = 1'b0;
      wait_ticks(1);
      @(negedge clk_in) rx_in = v;
      wait_ticks(7);
    end else begin
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (i == glitch_bit));
    drive_bit(stop_v, 1'b0);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clk_in) rx_in = 1'b1;
    wait_ticks(16 * n);
  endtask

  logic [7:0] lb_bytes[4];
  logic [7:0] exp_glitch;
  int last;

  initial begin
    lb_bytes[0] = 8'hA5;
    lb_bytes[1] = 8'h00;
    lb_bytes[2] = 8'hFF;
    lb_bytes[3] = 8'h01;

    rst_in = 1'b1;
    rx_in  = 1'b1;
    repeat (4) @(negedge clk_in);
    check("rst_data", {24'd0, data_out}, 32'h0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_ferr", {31'd0, framing_err_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    rst_in = 1'b0;
    idle_bits(2);

    // Loopback-style bytes.
    for (int k = 0; k < 4; k++) begin
      send_frame(lb_bytes[k], 1'b1, -1);
      exp_v++;
      check("lb_count", vcnt, exp_v);
      last = got_q.size() - 1;
      check("lb_data", (last >= 0) ? {24'd0, got_q[last]} : 32'hFFFF_FFFF, {24'd0, lb_bytes[k]});
    end
    idle_bits(1);

    // Short start glitch: 3 low ticks then high.
    @(negedge clk_in) rx_in = 1'b0;
    wait_ticks(3);
    @(negedge clk_in) rx_in = 1'b1;
    wait_ticks(4);
    @(negedge clk_in);
    check("glitch_busy_mid", {31'd0, busy_out}, 32'd1);
    wait_ticks(2);
    @(negedge clk_in);
    check("glitch_busy_after", {31'd0, busy_out}, 32'd0);
    idle_bits(2);
    check("glitch_no_valid", vcnt, exp_v);

    // Framing error on 0x3C.
    send_frame(8'h3C, 1'b0, -1);
    idle_bits(2);
    check("ferr_count", fcnt, 1);
    check("ferr_no_valid", vcnt, exp_v);
    check("ferr_data_held", {24'd0, data_out}, 32'h01);

    // Back-to-back frames, zero idle gap.
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hAA, 1'b1, -1);
    exp_v += 2;
    idle_bits(1);
    check("b2b_count", vcnt, exp_v);
    last = got_q.size() - 1;
    check("b2b_first", (last >= 1) ? {24'd0, got_q[last-1]} : 32'hFFFF_FFFF, 32'h55);
    check("b2b_second", (last >= 0) ? {24'd0, got_q[last]} : 32'hFFFF_FFFF, 32'hAA);

    // Reset during bit 4 of 0xF0.
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    @(negedge clk_in) rx_in = 1'b1;
    wait_ticks(8);
    @(negedge clk_in) rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("midrst_busy", {31'd0, busy_out}, 32'd0);
    check("midrst_data", {24'd0, data_out}, 32'h0);
    rst_in = 1'b0;
    idle_bits(2);
    check("midrst_no_valid", vcnt, exp_v);
    send_frame(8'h0F, 1'b1, -1);
    exp_v++;
    idle_bits(1);
    check("post_rst_count", vcnt, exp_v);
    check("post_rst_data", {24'd0, data_out}, 32'h0F);

    // One-tick low glitch at the centre of data bit 3 of 0xFF.
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'hFF;
`else
    exp_glitch = 8'hF7;
`endif
    send_frame(8'hFF, 1'b1, 3);
    exp_v++;
    idle_bits(1);
    check("maj_count", vcnt, exp_v);
    check("maj_data", {24'd0, data_out}, {24'd0, exp_glitch});

    check("ferr_total", fcnt, 1);
    check("valid_and_ferr", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
